subleq_control: RTL and testbench
=================================

Name: subleq_control

Overview:
- Instruction sequencer for the SUBLEQ core; sole master of the unified word-addressed memory block (load/store/addr/mem_in/mem_out interface).
- Fetches operands A, B, C at PC, PC+1, PC+2; reads mem[A] and mem[B]; writes mem[B] - mem[A] back to B; branches to C if the result is <= 0 (signed), else advances PC by 3.
- Provides run/halt control and an instruction counter for the testbench and top level.

Parameters:
- W, `WORD_SIZE (from defines.vh): word and address width; memory depth is 2^W.
- HALT_ADDR, {W{1'b1}}: a taken branch to this address halts the core.

Ports:
- clk  input  1  system clock, all state updates on posedge
- areset  input  1  reset, synchronous, active-high
- run  input  1  level; execute while high
- load  output  1  memory read enable
- store  output  1  memory write enable (sampled by memory at posedge clk)
- addr  output  W  memory address
- mem_in  output  W  write data to memory
- mem_out  input  W  read data from memory, combinational from addr while load=1
- pc  output  W  current program counter
- halted  output  1  core stopped on HALT_ADDR branch
- instr_count  output  W  retired instructions, wraps mod 2^W

Behaviour:
- Clock is clk; reset is areset, synchronous and active-high. Reset sets state=IDLE, pc=0, halted=0, instr_count=0, and clears the internal registers ra, rb, rc, va.
- Outputs load/store/addr/mem_in are combinational from the state and registers. In IDLE and HALT: load=0, store=0, addr=0, mem_in=0.
- store is forced to 0 whenever areset=1, so reset during WRITE_B produces no memory write.
- States, one cycle each; an instruction takes 6 cycles:
  - IDLE: if run, go to FETCH_A.
  - FETCH_A: load=1, addr=pc; ra<=mem_out.
  - FETCH_B: load=1, addr=pc+1; rb<=mem_out.
  - FETCH_C: load=1, addr=pc+2; rc<=mem_out.
  - READ_A: load=1, addr=ra; va<=mem_out.
  - READ_B: load=1, addr=rb; res<=mem_out-va (mod 2^W).
  - WRITE_B: store=1, addr=rb, mem_in=res. Branch is taken if res==0 or res[W-1]==1.
- WRITE_B exit, in priority order:
  - Taken and rc==HALT_ADDR: go to HALT, halted<=1. pc keeps the halting instruction's address. instr_count increments.
  - Otherwise: pc<=taken ? rc : pc+3 (mod 2^W), instr_count+1, then FETCH_A if run, else IDLE.
- run is sampled only in IDLE and at WRITE_B exit. Dropping run mid-instruction completes that instruction.
- HALT is left only by reset.
- Address arithmetic pc+1, pc+2, pc+3 wraps mod 2^W.
- A=B is legal: the result is 0, so the branch is taken.
- The write in WRITE_B is visible to the next fetch (the memory updates at the same edge).

Optional Feature:
- SUBLEQ_STEP_EN:
  - Defined: adds input port step (1 bit). In IDLE, a step pulse starts exactly one instruction even with run=0. After WRITE_B the core returns to IDLE unless run=1. If run=1 and step=1 together, run wins.
  - Undefined: no step port; behaviour is exactly as above.

Test Plan:
- W=8; mem[0..2]=10,11,0x30; mem[10]=2, mem[11]=5; reset, then run=1.
  - Expect addr sequence 0,1,2,10,11,11 with store=1 only in cycle 6.
  - Expect mem[11]=3, pc=3, instr_count=1 after 6 cycles.
- Zero and negative results:
  - mem[10]=5, mem[11]=5: expect mem[11]=0 and pc=0x30 (taken).
  - mem[10]=6, mem[11]=5: expect mem[11]=0xFF and pc=0x30.
- Halt: instruction 10,11,0xFF with a taken result.
  - Expect halted=1 after WRITE_B, pc=0, load=store=0 thereafter.
  - run toggling has no effect; areset clears halted.
- run dropped during FETCH_C: expect the instruction to complete, state=IDLE, pc=3.
- Reset held in WRITE_B: expect no store to mem[rb], then pc=0 and instr_count=0.
- PC wrap: pc=0xFE with a not-taken instruction.
  - Expect fetches from 0xFE, 0xFF, 0x00, then pc=0x01.
  - With SUBLEQ_STEP_EN and run=0, a single step pulse retires exactly 1 instruction, then the core sits in IDLE.

Source files
------------

// File: rtl/subleq_control.sv
// -----------------------------------------------------------------------------
// subleq_control
//
// Purpose:
//   Instruction sequencer for the SUBLEQ core. It is the only master of the
//   unified word-addressed memory. Each instruction runs in six states:
//     FETCH_A, FETCH_B, FETCH_C : read operand words A, B, C at pc, pc+1, pc+2
//     READ_A, READ_B            : read mem[A], then form res = mem[B] - mem[A]
//     WRITE_B                   : write res to mem[B], then branch or advance
//   The branch to C is taken when res <= 0 (signed). Otherwise pc advances
//   by 3. A taken branch to HALT_ADDR parks the core in HALT until reset.
//
// Configuration:
//   W defaults to 8, the WORD_SIZE of the core.
//   SUBLEQ_STEP_EN : when defined, adds the 'step' input. A step pulse in
//                    IDLE starts exactly one instruction even with run=0.
//
// Ports:
//   clk          in   system clock, all state updates on posedge
//   areset       in   synchronous active-high reset
//   run          in   level, execute while high (sampled in IDLE and at
//                     WRITE_B exit only)
//   step         in   (SUBLEQ_STEP_EN only) single-instruction request
//   load         out  memory read enable
//   store        out  memory write enable, forced low while areset=1
//   addr         out  memory address
//   mem_in       out  write data to memory
//   mem_out      in   read data, combinational from addr while load=1
//   pc           out  program counter
//   halted       out  core stopped on a HALT_ADDR branch
//   instr_count  out  retired instructions, wraps mod 2^W
//   dbg_state    out  current FSM state encoding for observation
//
// Memory handshake: the memory answers a read in the same cycle (load=1,
// addr valid -> mem_out valid before the next posedge) and commits a write
// at the posedge that ends a cycle with store=1. There is no back-pressure.
// -----------------------------------------------------------------------------
module subleq_control #(
    parameter int          W         = 8,
    parameter logic [W-1:0] HALT_ADDR = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         areset,
    input  logic         run,
`ifdef SUBLEQ_STEP_EN
    input  logic         step,
`endif
    output logic         load,
    output logic         store,
    output logic [W-1:0] addr,
    output logic [W-1:0] mem_in,
    input  logic [W-1:0] mem_out,
    output logic [W-1:0] pc,
    output logic         halted,
    output logic [W-1:0] instr_count,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH_A = 3'd1,
        S_FETCH_B = 3'd2,
        S_FETCH_C = 3'd3,
        S_READ_A  = 3'd4,
        S_READ_B  = 3'd5,
        S_WRITE_B = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    localparam logic [W-1:0] ONE   = W'(1);
    localparam logic [W-1:0] TWO   = W'(2);
    localparam logic [W-1:0] THREE = W'(3);

    state_t       state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic         halted_q, halted_d;
    logic [W-1:0] ra_q, ra_d;
    logic [W-1:0] rb_q, rb_d;
    logic [W-1:0] rc_q, rc_d;
    logic [W-1:0] va_q, va_d;
    logic [W-1:0] res_q, res_d;

    logic start_req;
    logic taken;
    logic halt_hit;
    logic store_raw;

`ifdef SUBLEQ_STEP_EN
    // run has priority; a step only matters when run is low, and either
    // way the core leaves IDLE the same way.
    assign start_req = run | step;
`else
    assign start_req = run;
`endif

    // res <= 0 as a signed number: zero or sign bit set.
    assign taken    = (res_q == '0) | res_q[W-1];
    assign halt_hit = taken & (rc_q == HALT_ADDR);

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_req) state_d = S_FETCH_A;
            S_FETCH_A: state_d = S_FETCH_B;
            S_FETCH_B: state_d = S_FETCH_C;
            S_FETCH_C: state_d = S_READ_A;
            S_READ_A:  state_d = S_READ_B;
            S_READ_B:  state_d = S_WRITE_B;
            S_WRITE_B: begin
                if (halt_hit)  state_d = S_HALT;
                else if (run)  state_d = S_FETCH_A;
                else           state_d = S_IDLE;
            end
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_IDLE;
        endcase
    end

    // ---------------- memory-interface outputs ----------------
    always_comb begin
        load      = 1'b0;
        store_raw = 1'b0;
        addr      = '0;
        mem_in    = '0;
        case (state_q)
            S_FETCH_A: begin load = 1'b1; addr = pc_q;         end
            S_FETCH_B: begin load = 1'b1; addr = pc_q + ONE;   end
            S_FETCH_C: begin load = 1'b1; addr = pc_q + TWO;   end
            S_READ_A:  begin load = 1'b1; addr = ra_q;         end
            S_READ_B:  begin load = 1'b1; addr = rb_q;         end
            S_WRITE_B: begin store_raw = 1'b1; addr = rb_q; mem_in = res_q; end
            default:   ;
        endcase
    end

    // Reset asserted during WRITE_B must not corrupt memory.
    assign store = store_raw & ~areset;

    // ---------------- datapath next-state ----------------
    always_comb begin
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;
        ra_d     = ra_q;
        rb_d     = rb_q;
        rc_d     = rc_q;
        va_d     = va_q;
        res_d    = res_q;
        case (state_q)
            S_FETCH_A: ra_d  = mem_out;
            S_FETCH_B: rb_d  = mem_out;
            S_FETCH_C: rc_d  = mem_out;
            S_READ_A:  va_d  = mem_out;
            S_READ_B:  res_d = mem_out - va_q;
            S_WRITE_B: begin
                cnt_d = cnt_q + ONE;
                if (halt_hit) begin
                    // pc stays on the halting instruction for inspection.
                    halted_d = 1'b1;
                end else begin
                    pc_d = taken ? rc_q : (pc_q + THREE);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            pc_q     <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            va_q     <= '0;
            res_q    <= '0;
        end else begin
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            ra_q     <= ra_d;
            rb_q     <= rb_d;
            rc_q     <= rc_d;
            va_q     <= va_d;
            res_q    <= res_d;
        end
    end

    assign pc          = pc_q;
    assign halted      = halted_q;
    assign instr_count = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_subleq_control.sv
// -----------------------------------------------------------------------------
// tb_subleq_control
//   Bench for subleq_control with W=8. A behavioural memory sits on the bus.
//   Table vectors each run one instruction; the expected bus transfers are
//   queued when the vector is set up and popped as the DUT drives the bus.
//   Hand-written sequences cover halt, run drop, reset in WRITE_B, pc wrap
//   and (with SUBLEQ_STEP_EN) single-stepping.
// -----------------------------------------------------------------------------
module tb_subleq_control;

    localparam int W = 8;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WRB  = 3'd6;
    localparam logic [2:0] ST_HALT = 3'd7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         areset;
    logic         run;
`ifdef SUBLEQ_STEP_EN
    logic         step;
`endif
    logic         load, store, halted;
    logic [W-1:0] addr, mem_in, mem_out, pc, instr_count;
    logic [2:0]   dbg_state;

    subleq_control #(.W(W)) dut (
        .clk         (clk),
        .areset      (areset),
        .run         (run),
`ifdef SUBLEQ_STEP_EN
        .step        (step),
`endif
        .load        (load),
        .store       (store),
        .addr        (addr),
        .mem_in      (mem_in),
        .mem_out     (mem_out),
        .pc          (pc),
        .halted      (halted),
        .instr_count (instr_count),
        .dbg_state   (dbg_state)
    );

    // ---------------- memory model ----------------
    logic [W-1:0] mem [256];
    logic         tb_we;
    logic [W-1:0] tb_wa, tb_wd;

    always @(posedge clk) begin
        if (store)      mem[addr]  <= mem_in;
        else if (tb_we) mem[tb_wa] <= tb_wd;
    end
    assign mem_out = load ? mem[addr] : '0;

    // ---------------- scoreboard ----------------
    // Entry layout: {load, store, addr, mem_in (0 unless store)}
    localparam int EW = 2 + 2 * W;
    logic [EW-1:0] exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic l, input logic s, input logic [W-1:0] a, input logic [W-1:0] d);
        exp_q.push_back({l, s, a, d});
    endtask

    task automatic sample_bus();
        logic [EW-1:0] got;
        if (load | store) begin
            got = {load, store, addr, (store ? mem_in : 8'h00)};
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_extra: got %0h expected no transfer", got);
            end else begin
                chk("bus", 32'(got), 32'(exp_q.pop_front()));
            end
        end
    endtask

    // One clock: sample at the negedge, return 1 time unit after posedge.
    task automatic tick();
        @(negedge clk);
        if (mon_en) sample_bus();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_write(input logic [W-1:0] a, input logic [W-1:0] d);
        tb_we = 1'b1; tb_wa = a; tb_wd = d;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        run    = 1'b0;
`ifdef SUBLEQ_STEP_EN
        step   = 1'b0;
`endif
        tick();
        tick();
    endtask

    // Program "A=10, B=11, C=c" at addr 0 with given operand values.
    task automatic load_prog(input logic [W-1:0] c, input logic [W-1:0] va, input logic [W-1:0] vb);
        mem_write(8'd0, 8'd10);
        mem_write(8'd1, 8'd11);
        mem_write(8'd2, c);
        mem_write(8'd10, va);
        mem_write(8'd11, vb);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] c;
        logic [W-1:0] exp_res;
        logic [W-1:0] exp_pc;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{va: 8'h02, vb: 8'h05, c: 8'h30, exp_res: 8'h03, exp_pc: 8'h03};
        vecs[1] = '{va: 8'h05, vb: 8'h05, c: 8'h30, exp_res: 8'h00, exp_pc: 8'h30};
        vecs[2] = '{va: 8'h06, vb: 8'h05, c: 8'h30, exp_res: 8'hFF, exp_pc: 8'h30};
        vecs[3] = '{va: 8'h01, vb: 8'h81, c: 8'h30, exp_res: 8'h80, exp_pc: 8'h30};
        vecs[4] = '{va: 8'h00, vb: 8'h7F, c: 8'h30, exp_res: 8'h7F, exp_pc: 8'h03};
        vecs[5] = '{va: 8'hFF, vb: 8'h7F, c: 8'h40, exp_res: 8'h80, exp_pc: 8'h40};
        vecs[6] = '{va: 8'h7F, vb: 8'h80, c: 8'h40, exp_res: 8'h01, exp_pc: 8'h03};

        tb_we = 1'b0; tb_wa = '0; tb_wd = '0;

        // ---- reset state ----
        do_reset();
        chk("rst_pc",     32'(pc), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_count",  32'(instr_count), 0);
        chk("rst_state",  32'(dbg_state), 32'(ST_IDLE));
        chk("rst_bus",    32'({load, store, addr, mem_in}), 0);

        // ---- table: one instruction each ----
        for (int i = 0; i < 7; i++) begin
            do_reset();
            load_prog(vecs[i].c, vecs[i].va, vecs[i].vb);
            exp_q.delete();
            push_bus(1, 0, 8'd0,  8'd0);
            push_bus(1, 0, 8'd1,  8'd0);
            push_bus(1, 0, 8'd2,  8'd0);
            push_bus(1, 0, 8'd10, 8'd0);
            push_bus(1, 0, 8'd11, 8'd0);
            push_bus(0, 1, 8'd11, vecs[i].exp_res);
            areset = 1'b0;
            mon_en = 1'b1;
            run = 1'b1;
            tick();               // IDLE -> FETCH_A
            run = 1'b0;           // stop after this instruction
            for (int k = 0; k < 9; k++) tick();
            mon_en = 1'b0;
            chk("vec_drained", 32'(exp_q.size()), 0);
            chk("vec_mem",     32'(mem[11]), 32'(vecs[i].exp_res));
            chk("vec_pc",      32'(pc), 32'(vecs[i].exp_pc));
            chk("vec_count",   32'(instr_count), 1);
            chk("vec_state",   32'(dbg_state), 32'(ST_IDLE));
        end

        // ---- halt ----
        begin
            int n;
            do_reset();
            load_prog(8'hFF, 8'h05, 8'h05);
            areset = 1'b0;
            run = 1'b1;
            n = 0;
            while (!halted && n < 30) begin tick(); n++; end
            chk("halt_reached", 32'(halted), 1);
            chk("halt_pc",      32'(pc), 0);
            chk("halt_count",   32'(instr_count), 1);
            chk("halt_mem",     32'(mem[11]), 0);
            for (int k = 0; k < 6; k++) begin
                run = k[0];
                tick();
                chk("halt_quiet", 32'({load, store}), 0);
                chk("halt_state", 32'(dbg_state), 32'(ST_HALT));
            end
            chk("halt_count_hold", 32'(instr_count), 1);
            areset = 1'b1;
            run = 1'b0;
            tick();
            chk("halt_cleared", 32'(halted), 0);
            chk("halt_rst_state", 32'(dbg_state), 32'(ST_IDLE));
        end

        // ---- run dropped during FETCH_C ----
        do_reset();
        load_prog(8'h30, 8'h02, 8'h05);
        areset = 1'b0;
        run = 1'b1;
        tick(); tick(); tick();   // FETCH_A, FETCH_B, FETCH_C
        run = 1'b0;
        for (int k = 0; k < 7; k++) tick();
        chk("drop_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("drop_pc",    32'(pc), 3);
        chk("drop_count", 32'(instr_count), 1);
        chk("drop_mem",   32'(mem[11]), 3);

        // ---- reset held in WRITE_B ----
        do_reset();
        load_prog(8'h30, 8'h02, 8'h05);
        areset = 1'b0;
        run = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("wrb_reached", 32'(dbg_state), 32'(ST_WRB));
        areset = 1'b1;
        run = 1'b0;
        #1;
        chk("wrb_store_blocked", 32'(store), 0);
        tick();
        tick();
        chk("wrb_mem_kept", 32'(mem[11]), 5);
        chk("wrb_pc",       32'(pc), 0);
        chk("wrb_count",    32'(instr_count), 0);
        chk("wrb_state",    32'(dbg_state), 32'(ST_IDLE));

        // ---- pc wrap: branch to 0xFE, then a not-taken instruction ----
        do_reset();
        mem_write(8'd0,  8'd20);
        mem_write(8'd1,  8'd20);
        mem_write(8'd2,  8'hFE);
        mem_write(8'd20, 8'h33);
        mem_write(8'hFE, 8'd10);
        mem_write(8'hFF, 8'd11);
        mem_write(8'd10, 8'h02);
        mem_write(8'd11, 8'h05);
        exp_q.delete();
        push_bus(1, 0, 8'd0,  8'd0);
        push_bus(1, 0, 8'd1,  8'd0);
        push_bus(1, 0, 8'd2,  8'd0);
        push_bus(1, 0, 8'd20, 8'd0);
        push_bus(1, 0, 8'd20, 8'd0);
        push_bus(0, 1, 8'd20, 8'h00);   // A=B -> 0, taken to 0xFE
        push_bus(1, 0, 8'hFE, 8'd0);
        push_bus(1, 0, 8'hFF, 8'd0);
        push_bus(1, 0, 8'h00, 8'd0);    // C fetched from wrapped address
        push_bus(1, 0, 8'd10, 8'd0);
        push_bus(1, 0, 8'd11, 8'd0);
        push_bus(0, 1, 8'd11, 8'h03);
        areset = 1'b0;
        mon_en = 1'b1;
        run = 1'b1;
        for (int k = 0; k < 7; k++) tick();   // through first WRITE_B exit
        run = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        mon_en = 1'b0;
        chk("wrap_drained", 32'(exp_q.size()), 0);
        chk("wrap_pc",      32'(pc), 32'h01);
        chk("wrap_count",   32'(instr_count), 2);
        chk("wrap_mem",     32'(mem[11]), 3);
        chk("wrap_state",   32'(dbg_state), 32'(ST_IDLE));

`ifdef SUBLEQ_STEP_EN
        // ---- single step with run low ----
        do_reset();
        load_prog(8'h30, 8'h02, 8'h05);
        areset = 1'b0;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        chk("step_count", 32'(instr_count), 1);
        chk("step_pc",    32'(pc), 3);
        chk("step_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("step_mem",   32'(mem[11]), 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
